// File: rtl/consumer_txn_reorder_ctrl.sv
// rtl/consumer_txn_reorder_ctrl.sv - tags consumer reads with rotating IDs, returns out-of-order memory responses in request order
// One FREE/ISSUED/DONE state per ID; the ID ring is allocated and released strictly in order.
module consumer_txn_reorder_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [ID_WIDTH-1:0]   mem_req_id_o,
  input  logic                  mem_resp_valid_i,
  input  logic [ID_WIDTH-1:0]   mem_resp_id_i,
  input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [ID_WIDTH:0]     outstanding_o,
  output logic                  error_o
);
  localparam int NUM_ENTRIES = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] LP_FULL = (ID_WIDTH+1)'(NUM_ENTRIES);

  typedef enum logic [1:0] {ST_FREE, ST_ISSUED, ST_DONE} entry_state_t;

  entry_state_t          r_state [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0] r_data  [NUM_ENTRIES];
  logic [ID_WIDTH-1:0]   r_alloc_ptr;
  logic [ID_WIDTH-1:0]   r_rel_ptr;
  logic [ID_WIDTH:0]     r_count;
  logic                  r_mem_req_valid;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic [ID_WIDTH-1:0]   r_mem_req_id;
  logic                  r_error;

  logic w_alloc;
  logic w_capture;
  logic w_resp_valid;
  logic w_release;

  // A pending memory request may be replaced in the same cycle it is accepted.
  assign req_ready_o  = (r_count < LP_FULL) && (!r_mem_req_valid || mem_req_ready_i);
  assign w_alloc      = req_valid_i && req_ready_o;
  assign w_capture    = mem_resp_valid_i && (r_state[mem_resp_id_i] == ST_ISSUED);
  assign w_resp_valid = (r_state[r_rel_ptr] == ST_DONE);
  assign w_release    = w_resp_valid && resp_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_state[i] <= ST_FREE;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_alloc && (r_alloc_ptr == ID_WIDTH'(i))) begin
          r_state[i] <= ST_ISSUED;
        end else if (w_capture && (mem_resp_id_i == ID_WIDTH'(i))) begin
          r_state[i] <= ST_DONE;
          r_data[i]  <= mem_resp_data_i;
        end else if (w_release && (r_rel_ptr == ID_WIDTH'(i))) begin
          r_state[i] <= ST_FREE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_alloc_ptr     <= '0;
      r_rel_ptr       <= '0;
      r_count         <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_id    <= '0;
      r_error         <= 1'b0;
    end else begin
      if (w_alloc) begin
        r_alloc_ptr     <= r_alloc_ptr + 1'b1;
        r_mem_req_valid <= 1'b1;
        r_mem_req_addr  <= req_addr_i;
        r_mem_req_id    <= r_alloc_ptr;
      end else if (mem_req_ready_i) begin
        r_mem_req_valid <= 1'b0;
        r_mem_req_addr  <= '0;
        r_mem_req_id    <= '0;
      end
      if (w_release) begin
        r_rel_ptr <= r_rel_ptr + 1'b1;
      end
      case ({w_alloc, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Responses for FREE or DONE IDs are dropped and flagged.
      if (mem_resp_valid_i && !w_capture) begin
        r_error <= 1'b1;
      end
    end
  end

  assign mem_req_valid_o = r_mem_req_valid;
  assign mem_req_addr_o  = r_mem_req_addr;
  assign mem_req_id_o    = r_mem_req_id;
  assign resp_valid_o    = w_resp_valid;
  assign resp_data_o     = r_data[r_rel_ptr];
  assign outstanding_o   = r_count;
  assign error_o         = r_error;

endmodule

// File: tb/tb_consumer_txn_reorder_ctrl.sv
// tb/tb_consumer_txn_reorder_ctrl.sv - scoreboard bench for consumer_txn_reorder_ctrl
// Expected memory requests and in-order responses are queued at issue time and popped by a monitor.
module tb_consumer_txn_reorder_ctrl;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int DW = 64;
  localparam int NE = 16;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [AW-1:0] mem_req_addr_o;
  logic [IW-1:0] mem_req_id_o;
  logic          mem_resp_valid_i = 1'b0;
  logic [IW-1:0] mem_resp_id_i = '0;
  logic [DW-1:0] mem_resp_data_i = '0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [DW-1:0] resp_data_o;
  logic [IW:0]   outstanding_o;
  logic          error_o;

  consumer_txn_reorder_ctrl #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_id_i(mem_resp_id_i),
    .mem_resp_data_i(mem_resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [AW-1:0] addr; logic [IW-1:0] id; } mreq_t;
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] data; } pend_t;

  mreq_t         exp_mem[$];
  logic [DW-1:0] exp_resp[$];
  pend_t         pending[$];
  int            m_next_id = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            mem_mode = 0;
  int            resp_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Ready modes: 0 = low, 1 = high, 2 = random per cycle.
  always @(posedge clk_i) begin
    #2;
    mem_req_ready_i = (mem_mode == 2) ? 1'($urandom) : (mem_mode == 1);
    resp_ready_i    = (resp_mode == 2) ? 1'($urandom) : (resp_mode == 1);
  end

  always @(negedge clk_i) begin : monitor
    mreq_t         e;
    logic [DW-1:0] d;
    if (!reset_i) begin
      if (mem_req_valid_o && mem_req_ready_i) begin
        chk("mem_req_unexpected", 64'(exp_mem.size() == 0), 64'd0);
        if (exp_mem.size() > 0) begin
          e = exp_mem.pop_front();
          chk("mem_req_addr", mem_req_addr_o, e.addr);
          chk("mem_req_id", 64'(mem_req_id_o), 64'(e.id));
        end
      end
      if (resp_valid_o && resp_ready_i) begin
        chk("resp_unexpected", 64'(exp_resp.size() == 0), 64'd0);
        if (exp_resp.size() > 0) begin
          d = exp_resp.pop_front();
          chk("resp_data", resp_data_o, d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_model;
    exp_mem.delete();
    exp_resp.delete();
    pending.delete();
    m_next_id = 0;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    req_valid_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    clear_model();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk_i);
      ok = req_ready_o;
      tick();
    end
    req_valid_i = 1'b0;
    chk("req_accept", 64'(ok), 64'd1);
    if (ok) begin
      exp_mem.push_back('{addr: a, id: IW'(m_next_id)});
      exp_resp.push_back(d);
      pending.push_back('{id: IW'(m_next_id), data: d});
      m_next_id = (m_next_id + 1) % NE;
    end
  endtask

  task automatic respond(input logic [IW-1:0] id, input logic [DW-1:0] d);
    mem_resp_valid_i = 1'b1;
    mem_resp_id_i    = id;
    mem_resp_data_i  = d;
    tick();
    mem_resp_valid_i = 1'b0;
  endtask

  task automatic respond_pending(input int idx);
    pend_t p;
    p = pending[idx];
    pending.delete(idx);
    respond(p.id, p.data);
  endtask

  task automatic drain;
    bit done;
    done = 1'b0;
    while (pending.size() > 0) respond_pending($urandom_range(pending.size() - 1));
    mem_mode  = 1;
    resp_mode = 1;
    for (int n = 0; n < 300 && !done; n++) begin
      tick();
      done = (exp_resp.size() == 0) && (exp_mem.size() == 0);
    end
    chk("drain_done", 64'(done), 64'd1);
    chk("drain_outstanding", 64'(outstanding_o), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mem_valid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_mem_addr", mem_req_addr_o, 64'd0);
    chk("rst_mem_id", 64'(mem_req_id_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    reset_i = 1'b0;

    // Single read
    do_reset();
    mem_mode = 1; resp_mode = 0;
    issue(64'h1000, 64'hAB);
    chk("single_mem_valid", 64'(mem_req_valid_o), 64'd1);
    chk("single_mem_id", 64'(mem_req_id_o), 64'd0);
    chk("single_mem_addr", mem_req_addr_o, 64'h1000);
    chk("single_resp_not_yet", 64'(resp_valid_o), 64'd0);
    respond_pending(0);
    chk("single_resp_valid", 64'(resp_valid_o), 64'd1);
    chk("single_resp_data", resp_data_o, 64'hAB);
    drain();

    // Out-of-order responses
    do_reset();
    mem_mode = 1; resp_mode = 0;
    issue(64'h0, 64'hC0);
    issue(64'h40, 64'hC1);
    issue(64'h80, 64'hC2);
    respond_pending(2);
    tick();
    chk("ooo_hold_low", 64'(resp_valid_o), 64'd0);
    respond_pending(0);
    chk("ooo_first_valid", 64'(resp_valid_o), 64'd1);
    chk("ooo_first_data", resp_data_o, 64'hC0);
    drain();

    // Full and wrap
    do_reset();
    mem_mode = 1; resp_mode = 0;
    for (int i = 0; i < NE; i++) issue(64'(i * 64), 64'(32'hF00 + i));
    tick();
    chk("full_ready_low", 64'(req_ready_o), 64'd0);
    chk("full_outstanding", 64'(outstanding_o), 64'd16);
    respond_pending(0);
    resp_mode = 1;
    @(negedge clk_i);
    chk("full_release_cycle_ready", 64'(req_ready_o), 64'd0);
    tick();
    resp_mode = 0;
    chk("after_release_ready", 64'(req_ready_o), 64'd1);
    chk("after_release_outstanding", 64'(outstanding_o), 64'd15);
    issue(64'h5000, 64'h1234);
    drain();

    // Memory request backpressure
    do_reset();
    mem_mode = 0; resp_mode = 0;
    issue(64'hA000, 64'h11);
    req_valid_i = 1'b1;
    req_addr_i  = 64'hB000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
      chk("bp_mem_valid", 64'(mem_req_valid_o), 64'd1);
      chk("bp_mem_addr", mem_req_addr_o, 64'hA000);
      chk("bp_mem_id", 64'(mem_req_id_o), 64'd0);
      tick();
    end
    req_valid_i = 1'b0;
    mem_mode = 1;
    issue(64'hB000, 64'h22);
    respond_pending(0);
    respond_pending(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("bp_resp_valid", 64'(resp_valid_o), 64'd1);
      chk("bp_resp_data", resp_data_o, 64'h11);
      tick();
    end
    drain();

    // Error on response to FREE entry
    do_reset();
    mem_mode = 1; resp_mode = 1;
    tick();
    chk("err_clear", 64'(error_o), 64'd0);
    respond(4'd5, 64'hEE);
    chk("err_set", 64'(error_o), 64'd1);
    issue(64'h7000, 64'h77);
    drain();
    chk("err_sticky", 64'(error_o), 64'd1);

    // Asynchronous reset mid-flight
    do_reset();
    mem_mode = 1; resp_mode = 0;
    issue(64'h100, 64'h1);
    issue(64'h200, 64'h2);
    issue(64'h300, 64'h3);
    #1;
    reset_i = 1'b1;
    #1;
    chk("arst_mem_valid", 64'(mem_req_valid_o), 64'd0);
    chk("arst_mem_addr", mem_req_addr_o, 64'd0);
    chk("arst_mem_id", 64'(mem_req_id_o), 64'd0);
    chk("arst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("arst_resp_data", resp_data_o, 64'd0);
    chk("arst_outstanding", 64'(outstanding_o), 64'd0);
    chk("arst_error", 64'(error_o), 64'd0);
    clear_model();
    tick();
    reset_i = 1'b0;
    issue(64'h9000, 64'h99);
    respond(4'd2, 64'h5);
    chk("arst_stale_resp_error", 64'(error_o), 64'd1);
    drain();

    // Randomized traffic
    do_reset();
    mem_mode = 2; resp_mode = 2;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(2);
      if (r == 0 && exp_resp.size() < NE)
        issue({$urandom, $urandom}, {$urandom, $urandom});
      else if (r == 1 && pending.size() > 0)
        respond_pending($urandom_range(pending.size() - 1));
      else
        tick();
    end
    drain();
    chk("rand_no_error", 64'(error_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/consumer_txn_reorder_ctrl.md
Name: consumer_txn_reorder_ctrl

Overview:
- Transaction controller between the cohort consumer's load engine and the memory request interface.
- Assigns a unique transaction ID to each consumer read, issues the request with that ID, and accepts out-of-order memory responses.
- Returns response data to the consumer strictly in request order.
- Holds at most 2**ID_WIDTH reads in flight; excess requests are backpressured.

Parameters:
- ADDR_WIDTH, 64, request address width (matches consumer transaction addr_t).
- ID_WIDTH, 4, transaction ID width (matches consumer transaction id_t); entry count NUM_ENTRIES = 2**ID_WIDTH.
- DATA_WIDTH, 64, response data width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  consumer read request valid.
- req_ready_o  out  1  controller accepts request.
- req_addr_i  in  ADDR_WIDTH  consumer read address.
- mem_req_valid_o  out  1  memory request valid (registered).
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  ADDR_WIDTH  memory request address.
- mem_req_id_o  out  ID_WIDTH  transaction ID of memory request.
- mem_resp_valid_i  in  1  memory response valid; always accepted, no ready.
- mem_resp_id_i  in  ID_WIDTH  ID of response.
- mem_resp_data_i  in  DATA_WIDTH  response data.
- resp_valid_o  out  1  in-order response to consumer valid.
- resp_ready_i  in  1  consumer accepts response.
- resp_data_o  out  DATA_WIDTH  in-order response data.
- outstanding_o  out  ID_WIDTH+1  allocated entries (ISSUED + DONE).
- error_o  out  1  sticky: response received for an ID not in ISSUED.

Behaviour:
- Reset (asynchronous, active-high):
  - All entries FREE; alloc_ptr = rel_ptr = 0; count = 0.
  - mem_req_valid_o = 0, mem_req_addr_o = 0, mem_req_id_o = 0.
  - resp_valid_o = 0, resp_data_o = 0, outstanding_o = 0, error_o = 0.
  - Reset mid-operation drops all in-flight state; responses for pre-reset IDs arriving after reset set error_o.
- Per-entry state machine, one per ID: FREE -> ISSUED on allocation; ISSUED -> DONE on matching response, data captured; DONE -> FREE on consumer response handshake.
- Allocation:
  - req_ready_o = (count < NUM_ENTRIES) && (!mem_req_valid_o || mem_req_ready_i).
  - On req_valid_i && req_ready_o: entry[alloc_ptr] <= ISSUED; mem_req_valid_o <= 1; mem_req_addr_o <= req_addr_i; mem_req_id_o <= alloc_ptr; alloc_ptr increments, wrapping modulo NUM_ENTRIES.
  - Consumer handshake to mem_req_valid_o latency: 1 cycle.
  - mem_req_valid_o, addr and id hold stable until mem_req_ready_i. They clear on ready only if no new allocation occurs that cycle, which gives back-to-back throughput of 1 request/cycle.
- Response capture:
  - On mem_resp_valid_i with entry[mem_resp_id_i] == ISSUED: store data, state becomes DONE.
  - Otherwise the response is dropped and error_o <= 1 (sticky until reset).
  - Capture is legal the cycle after the consumer handshake for that ID, including before the mem request handshake completes.
- Release:
  - resp_valid_o = (entry[rel_ptr] == DONE); resp_data_o = stored data of rel_ptr.
  - Both are driven from registered state, so a response captured in cycle N is presentable in cycle N+1.
  - On resp_valid_o && resp_ready_i: entry FREE, rel_ptr increments with wrap.
  - resp_valid_o/resp_data_o stay stable while resp_ready_i is low.
- Count:
  - +1 on allocation, -1 on release; unchanged on a simultaneous allocate and release. outstanding_o = count.
  - Full (count == NUM_ENTRIES): req_ready_o = 0. A release in the full cycle does not raise ready until the next cycle.
  - Empty: resp_valid_o = 0.
- Same-cycle events: a response for ID k and a release of ID k are mutually exclusive by state. A response and a release for different IDs both take effect.

Test Plan:
- Single read: req addr 0x1000 -> mem_req_valid_o next cycle with id 0, addr 0x1000. Then resp id 0, data 0xAB -> resp_valid_o next cycle with data 0xAB. After the handshake, outstanding_o = 0.
- Out-of-order: issue ids 0,1,2 (addr 0x0,0x40,0x80); respond 2,0,1 with data 0xC2,0xC0,0xC1 -> consumer sees 0xC0,0xC1,0xC2 in that order. resp_valid_o stays low until id 0 arrives.
- Full/wrap: issue 16 reads with no responses -> req_ready_o low, outstanding_o = 16. Respond and release id 0 -> one cycle later req_ready_o high and the next request carries id 0.
- Backpressure:
  - Hold mem_req_ready_i low 3 cycles -> mem_req_addr_o/id_o stable, req_ready_o low.
  - Hold resp_ready_i low 4 cycles with 2 DONE entries -> resp_data_o holds the first value.
- Error: response with id 5 while entry 5 is FREE -> error_o rises next cycle and stays high; other entries are unaffected.
- Reset mid-flight: 3 ids ISSUED, assert reset_i asynchronously -> all outputs at reset values immediately. A subsequent request gets id 0.
